// File: rtl/io_map_pkg.sv
// Shared definitions for the KEY/SW memory-mapped responder: register map,
// status-register bit positions, per-device flag record and its update rule,
// and the debounce counter width helper.
package io_map_pkg;

    localparam logic [31:0] MAP_KEY   = 32'hF000_0010;
    localparam logic [31:0] MAP_SW    = 32'hF000_0014;
    localparam logic [31:0] MAP_KCTRL = 32'hF000_0110;
    localparam logic [31:0] MAP_SCTRL = 32'hF000_0114;

    localparam int unsigned READY_BIT   = 0;
    localparam int unsigned OVERRUN_BIT = 2;
    localparam int unsigned IE_BIT      = 8;

    typedef struct packed {
        logic ready;
        logic overrun;
        logic ie;
    } devFlags_t;

    function automatic int unsigned cntWidth(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

    // Next flag state for one device. A change event beats a clearing read on
    // ready; overrun is only raised when the old ready survives the edge, and a
    // raise beats a store that clears it.
    function automatic devFlags_t flagsNext(
        input devFlags_t cur,
        input logic      change,
        input logic      rdClr,
        input logic      wr,
        input logic      wrOverrun,
        input logic      wrIe
    );
        devFlags_t nxt;
        nxt = cur;
        if (change) begin
            nxt.ready = 1'b1;
        end else if (rdClr) begin
            nxt.ready = 1'b0;
        end
        if (wr) begin
            nxt.ie = wrIe;
            if (!wrOverrun) begin
                nxt.overrun = 1'b0;
            end
        end
        if (change && cur.ready && !rdClr) begin
            nxt.overrun = 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus optional debounce counter for a group of pins.
// Macro KEY_SW_DEBOUNCE_EN selects the counter; without it the synchronised
// value is accepted every cycle. INVERT flips the pin sense after the
// synchroniser (used for active-low pushbuttons).
module input_debouncer #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          INVERT          = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] dbState,
    output logic             change
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] syncOut;
    logic             update;

    if (DEBOUNCE_CYCLES < 1) begin : gBadCycles
        $error("input_debouncer: DEBOUNCE_CYCLES must be at least 1");
    end

    // Two-flop synchroniser; resets to the idle pin level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= {WIDTH{INVERT}};
            sync2 <= {WIDTH{INVERT}};
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    assign syncOut = INVERT ? ~sync2 : sync2;

`ifdef KEY_SW_DEBOUNCE_EN
    localparam int unsigned    CW   = io_map_pkg::cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] count;
    logic          pending;

    // Stability is judged on the sync1/sync2 pair, so a new value counts from
    // its first cycle at the debouncer input rather than one cycle later.
    always_comb begin
        pending = (syncOut != dbState) && (sync1 == sync2);
        update  = pending && (count == LAST);
    end

    // Stable-cycle counter; any glitch or return to the accepted value clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (pending && !update) begin
            count <= count + CW'(1);
        end else begin
            count <= '0;
        end
    end
`else
    assign update = 1'b1;
`endif

    assign change = update && (syncOut != dbState);

    // Accepted (debounced) pin state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbState <= '0;
        end else if (update) begin
            dbState <= syncOut;
        end
    end

endmodule

// File: rtl/key_sw_responder.sv
// Memory-mapped KEY/SW responder on the data-memory port. Serves the two data
// registers and two control/status registers, tracks ready/overrun/IE per
// device and raises intr. Debounce counters present when KEY_SW_DEBOUNCE_EN
// is defined.
module key_sw_responder
    import io_map_pkg::*;
#(
    parameter int unsigned          DBITS           = 32,
    parameter logic [DBITS-1:0]     ADDR_KEY        = DBITS'(MAP_KEY),
    parameter logic [DBITS-1:0]     ADDR_SW         = DBITS'(MAP_SW),
    parameter logic [DBITS-1:0]     ADDR_KCTRL      = DBITS'(MAP_KCTRL),
    parameter logic [DBITS-1:0]     ADDR_SCTRL      = DBITS'(MAP_SCTRL),
    parameter int unsigned          KEY_BITS        = 4,
    parameter int unsigned          SW_BITS         = 10,
    parameter int unsigned          DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DBITS-1:0]    addr,
    input  logic                rdEn,
    input  logic                wrtEn,
    input  logic [DBITS-1:0]    dIn,
    output logic [DBITS-1:0]    dOut,
    output logic                hit,
    input  logic [KEY_BITS-1:0] key,
    input  logic [SW_BITS-1:0]  sw,
    output logic                intr
);

    logic [KEY_BITS-1:0] keyDb;
    logic [SW_BITS-1:0]  swDb;
    logic                keyChange;
    logic                swChange;
    devFlags_t           kFlags;
    devFlags_t           sFlags;
    logic                selKey, selSw, selKctrl, selSctrl;
    logic                unusedDin;

    input_debouncer #(
        .WIDTH          (KEY_BITS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .INVERT         (1'b1)
    ) keyDeb (
        .clk    (clk),
        .reset  (reset),
        .pins   (key),
        .dbState(keyDb),
        .change (keyChange)
    );

    input_debouncer #(
        .WIDTH          (SW_BITS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .INVERT         (1'b0)
    ) swDeb (
        .clk    (clk),
        .reset  (reset),
        .pins   (sw),
        .dbState(swDb),
        .change (swChange)
    );

    assign selKey   = (addr == ADDR_KEY);
    assign selSw    = (addr == ADDR_SW);
    assign selKctrl = (addr == ADDR_KCTRL);
    assign selSctrl = (addr == ADDR_SCTRL);

    // Only the overrun and IE bits of a status store have a destination
    assign unusedDin = ^dIn;

    // Per-device ready/overrun/IE flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kFlags <= '0;
            sFlags <= '0;
        end else begin
            kFlags <= flagsNext(kFlags, keyChange, rdEn && selKey, wrtEn && selKctrl,
                                dIn[OVERRUN_BIT], dIn[IE_BIT]);
            sFlags <= flagsNext(sFlags, swChange, rdEn && selSw, wrtEn && selSctrl,
                                dIn[OVERRUN_BIT], dIn[IE_BIT]);
        end
    end

    // Combinational read mux and address hit
    always_comb begin
        dOut = '0;
        hit  = 1'b0;
        if (selKey) begin
            hit  = 1'b1;
            dOut = DBITS'(keyDb);
        end else if (selSw) begin
            hit  = 1'b1;
            dOut = DBITS'(swDb);
        end else if (selKctrl) begin
            hit               = 1'b1;
            dOut[READY_BIT]   = kFlags.ready;
            dOut[OVERRUN_BIT] = kFlags.overrun;
            dOut[IE_BIT]      = kFlags.ie;
        end else if (selSctrl) begin
            hit               = 1'b1;
            dOut[READY_BIT]   = sFlags.ready;
            dOut[OVERRUN_BIT] = sFlags.overrun;
            dOut[IE_BIT]      = sFlags.ie;
        end
    end

    assign intr = (kFlags.ready && kFlags.ie) || (sFlags.ready && sFlags.ie);

endmodule

// File: tb/tb_key_sw_responder.sv
// Directed self-checking bench for key_sw_responder (DEBOUNCE_CYCLES=4).
// Expected update latency follows KEY_SW_DEBOUNCE_EN.
module tb_key_sw_responder;

    localparam int unsigned DC = 4;
`ifdef KEY_SW_DEBOUNCE_EN
    localparam int unsigned LAT = 2 + DC;
`else
    localparam int unsigned LAT = 3;
`endif

    localparam logic [31:0] A_KEY   = 32'hF000_0010;
    localparam logic [31:0] A_SW    = 32'hF000_0014;
    localparam logic [31:0] A_KCTRL = 32'hF000_0110;
    localparam logic [31:0] A_SCTRL = 32'hF000_0114;
    localparam logic [31:0] A_NONE  = 32'hF000_0018;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        rdEn;
    logic        wrtEn;
    logic [31:0] dIn;
    logic [31:0] dOut;
    logic        hit;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic        intr;

    int errors = 0;
    int checks = 0;

    key_sw_responder #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .rdEn (rdEn),
        .wrtEn(wrtEn),
        .dIn  (dIn),
        .dOut (dOut),
        .hit  (hit),
        .key  (key),
        .sw   (sw),
        .intr (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic readReg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, dOut, exp);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        dIn   = d;
        wrtEn = 1'b1;
        tick();
        wrtEn = 1'b0;
        dIn   = '0;
    endtask

    initial begin
        reset = 1'b0;
        key   = 4'hF;
        sw    = '0;
        addr  = A_NONE;
        rdEn  = 1'b0;
        wrtEn = 1'b0;
        dIn   = '0;
        #2;
        check("intr_in_reset", intr, 0);
        #10;
        reset = 1'b1;
        ticks(3);

        // Reset state
        readReg("rst_key", A_KEY, 0);
        readReg("rst_sw", A_SW, 0);
        readReg("rst_kctrl", A_KCTRL, 0);
        readReg("rst_sctrl", A_SCTRL, 0);
        check("rst_hit", hit, 1);
        check("rst_intr", intr, 0);

        // KEY0 pressed before edge 1 and held
        key  = 4'hE;
        addr = A_KEY;
        for (int i = 1; i < LAT; i++) begin
            tick();
            check("key_before_accept", dOut, 0);
        end
        tick();
        check("key_accepted", dOut, 1);
        readReg("kctrl_ready", A_KCTRL, 1);
        addr = A_KEY;
        rdEn = 1'b1;
        #1;
        check("key_read_value", dOut, 1);
        tick();
        rdEn = 1'b0;
        readReg("kctrl_cleared", A_KCTRL, 0);
        readReg("key_held", A_KEY, 1);

        // Three-cycle glitch on SW0
        sw = 10'h001;
        ticks(3);
        sw = 10'h000;
        ticks(8);
`ifdef KEY_SW_DEBOUNCE_EN
        readReg("glitch_sw", A_SW, 0);
        readReg("glitch_sctrl", A_SCTRL, 0);
`else
        readReg("glitch_sw", A_SW, 0);
        readReg("glitch_sctrl", A_SCTRL, 32'h005);
        addr = A_SW;
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        store(A_SCTRL, 32'h0);
        readReg("glitch_cleanup", A_SCTRL, 0);
`endif

        // Two SW changes without a read -> overrun
        sw = 10'h200;
        ticks(LAT);
        readReg("sw_first", A_SW, 32'h200);
        readReg("sctrl_first", A_SCTRL, 32'h001);
        sw = 10'h201;
        ticks(LAT);
        readReg("sw_second", A_SW, 32'h201);
        readReg("sctrl_overrun", A_SCTRL, 32'h005);
        check("intr_ie_off", intr, 0);
        store(A_SCTRL, 32'h000);
        readReg("sctrl_ovr_clr", A_SCTRL, 32'h001);
        store(A_SCTRL, 32'h104);
        readReg("sctrl_ie_set", A_SCTRL, 32'h101);
        check("intr_sw", intr, 1);
        addr = A_SW;
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        readReg("sctrl_after_rd", A_SCTRL, 32'h100);
        check("intr_sw_cleared", intr, 0);

        // Release KEY0, then change coinciding with a clearing read
        key = 4'hF;
        ticks(LAT);
        readReg("key_released", A_KEY, 0);
        readReg("kctrl_release", A_KCTRL, 1);
        key = 4'hE;
        ticks(LAT - 1);
        addr = A_KEY;
        rdEn = 1'b1;
        #1;
        check("race_read_pre", dOut, 0);
        tick();
        rdEn = 1'b0;
        readReg("race_kctrl", A_KCTRL, 1);
        readReg("race_key", A_KEY, 1);

        // Overrun raised on the same edge as a clearing store: raise wins
        key = 4'hF;
        ticks(LAT - 1);
        store(A_KCTRL, 32'h000);
        readReg("set_wins_kctrl", A_KCTRL, 32'h005);
        readReg("set_wins_key", A_KEY, 0);
        store(A_KCTRL, 32'h100);
        readReg("kctrl_ie", A_KCTRL, 32'h101);
        check("intr_key", intr, 1);
        store(A_KCTRL, 32'h005);
        readReg("kctrl_bit0_ign", A_KCTRL, 32'h001);
        check("intr_key_off", intr, 0);

        // Store to a data register is ignored
        store(A_KEY, 32'hFFFF_FFFF);
        readReg("key_store_ign", A_KEY, 0);
        readReg("kctrl_store_ign", A_KCTRL, 32'h001);

        // Unmapped addresses
        rdEn = 1'b1;
        readReg("unmapped_dout", A_NONE, 0);
        check("unmapped_hit", hit, 0);
        readReg("near_miss_dout", 32'hF000_0011, 0);
        check("near_miss_hit", hit, 0);
        tick();
        rdEn = 1'b0;
        readReg("kctrl_unmapped_rd", A_KCTRL, 32'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
